// File: rtl/cla8_word_sequencer.sv
// ---------------------------------------------------------------------------
// cla8_word_sequencer
//
// Purpose:
//   Performs a wide (8*NBYTES bit) add or subtract by feeding an external
//   combinational 8-bit adder one byte slice per cycle, LSB first. The
//   adder's carry-out is fed back as the next slice's carry-in. The
//   assembled result is presented with carry-out and signed-overflow flags.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_a, in_b, in_cin, in_sub
//   add_a/add_b/add_cin slice presented to the external adder (0 when idle)
//   add_s/add_cout      adder result for the current slice
//   out_valid/out_ready result handshake; out_sum, out_cout, out_ovf
// ---------------------------------------------------------------------------
module cla8_word_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_sub,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_s,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;      // B already inverted for subtraction
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic            w_accept;
  logic            w_last;
  logic            w_ovf;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_idx == LAST_IDX);
  // Operands with equal sign whose sum has the opposite sign overflowed.
  assign w_ovf    = (r_a[W-1] == r_b[W-1]) && (add_s[7] != r_a[W-1]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake/adder outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    add_a        = 8'h00;
    add_b        = 8'h00;
    add_cin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        add_a   = r_a[8*r_idx +: 8];
        add_b   = r_b[8*r_idx +: 8];
        add_cin = r_carry;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b ^ {W{in_sub}};
      r_carry <= in_sub ? 1'b1 : in_cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[8*r_idx +: 8] <= add_s;
      r_carry             <= add_cout;
      if (w_last) begin
        r_cout <= add_cout;
        r_ovf  <= w_ovf;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_cla8_word_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla8_word_sequencer
//
// Directed bench for the 4-byte sequencer. An ideal 8-bit adder is modelled
// with a continuous assignment; expected results are hand-computed constants
// plus a reference W-bit sum for a short run of random operands.
// ---------------------------------------------------------------------------
module tb_cla8_word_sequencer;

  localparam int NBYTES = 4;
  localparam int W      = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External combinational 8-bit adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  cla8_word_sequencer #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands in IDLE and let the accept edge pass.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    @(negedge clk);
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs: only the accept-edge sample may matter.
    in_a = $urandom; in_b = $urandom; in_cin = ~cin; in_sub = ~sub;
  endtask

  // Count edges from accept until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] es,
                           input logic ec, input logic eo);
    int n;
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'(NBYTES));
    check({tag, "_sum"}, {32'd0, out_sum}, {32'd0, es});
    check({tag, "_cout"}, {63'd0, out_cout}, {63'd0, ec});
    check({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, eo});
    $display("op %s: sum=%h cout=%0d ovf=%0d edges=%0d", tag, out_sum, out_cout, out_ovf, n);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rbe, es;
    logic         rc, rs, ec, eo;
    logic [W:0]   full;
    int           n;

    // Reset state
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", {32'd0, out_sum}, 64'd0);
    check("rst_out_cout", {63'd0, out_cout}, 64'd0);
    check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    check("rst_add_bus", {54'd0, add_a, add_b, add_cin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed add/sub vectors
    start_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    finish_op("add_ripple", 32'h00000100, 1'b0, 1'b0);
    start_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    finish_op("add_cin_wrap", 32'h00000000, 1'b1, 1'b0);
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    finish_op("add_ovf", 32'h80000000, 1'b0, 1'b1);

    start_op(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    // First RUN slice of a subtract: B inverted, carry-in forced to 1.
    check("sub_slice0_a", {56'd0, add_a}, 64'h00);
    check("sub_slice0_b", {56'd0, add_b}, 64'hFE);
    check("sub_slice0_cin", {63'd0, add_cin}, 64'd1);
    check("run_in_ready", {63'd0, in_ready}, 64'd0);
    finish_op("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1);

    start_op(32'h00000005, 32'h00000007, 1'b0, 1'b1);
    finish_op("sub_borrow", 32'hFFFFFFFE, 1'b0, 1'b0);
    start_op(32'h00000007, 32'h00000005, 1'b0, 1'b1);
    finish_op("sub_noborrow", 32'h00000002, 1'b1, 1'b0);
    start_op(32'h0000000A, 32'h00000003, 1'b1, 1'b1);
    finish_op("sub_cin_ignored", 32'h00000007, 1'b1, 1'b0);
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    finish_op("add_mixed", 32'h23456789, 1'b0, 1'b0);
    start_op(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    finish_op("add_neg_ovf", 32'h00000000, 1'b1, 1'b1);

    // Backpressure: hold result 10 cycles while upstream pushes a new op
    start_op(32'h00010000, 32'h0000FFFF, 1'b1, 1'b0);
    wait_done(n);
    check("bp_latency", 64'(n), 64'(NBYTES));
    in_a = 32'hDEADBEEF; in_b = 32'h01010101; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_sum_held", {32'd0, out_sum}, 64'h00020000);
      check("bp_flags_held", {62'd0, out_cout, out_ovf}, 64'd0);
    end
    $display("op bp: held sum=%h for 10 cycles", out_sum);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_valid_drop", {63'd0, out_valid}, 64'd0);
    check("bp_ready_back", {63'd0, in_ready}, 64'd1);
    // The request offered during DONE must not have been taken.
    repeat (2) @(negedge clk);
    check("bp_no_ghost_op", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset in the middle of RUN (idx=2)
    start_op(32'h11223344, 32'h01020304, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_slice2_a", {56'd0, add_a}, 64'h22);
    check("mid_slice2_b", {56'd0, add_b}, 64'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out_sum", {32'd0, out_sum}, 64'd0);
    check("mid_rst_flags", {62'd0, out_cout, out_ovf}, 64'd0);
    check("mid_rst_add_bus", {54'd0, add_a, add_b, add_cin}, 64'd0);
    $display("op mid_rst: reset asserted during slice 2");
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'hCAFEF00D, 32'h35010FF3, 1'b0, 1'b0);
    finish_op("after_rst", 32'h00000000, 1'b1, 1'b0);

    // Random operands against a W-bit reference sum
    for (int k = 0; k < 200; k++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      rbe  = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, rbe} + {32'd0, (rs ? 1'b1 : rc)};
      es   = full[W-1:0];
      ec   = full[W];
      eo   = (ra[W-1] == rbe[W-1]) && (es[W-1] != ra[W-1]);
      start_op(ra, rb, rc, rs);
      finish_op($sformatf("rand%0d", k), es, ec, eo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
